// File: rtl/rv32i_sim_pkg.sv
// Shared definitions for the RV32I core simulation/run-control blocks:
// run-control FSM encodings, pipeline stage indices and small elaboration helpers.
package rv32i_sim_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HOLD    = 3'd1,
    S_RELEASE = 3'd2,
    S_RUN     = 3'd3,
    S_DRAIN   = 3'd4,
    S_DONE    = 3'd5
  } run_state_e;

  localparam int IF_CH  = 0;
  localparam int ID_CH  = 1;
  localparam int EX_CH  = 2;
  localparam int MEM_CH = 3;
  localparam int WB_CH  = 4;

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/run_ctrl_timer.sv
// Loadable down-counter with a zero flag; shared by the HOLD, stagger and
// DRAIN phases of core_run_ctrl. Stops at zero rather than wrapping.
module run_ctrl_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (en && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/core_run_ctrl.sv
// Reset sequencing and run control for the RV32I cores: staggered per-stage
// reset release, run/drain cycle counting, watchdog. Optional retire statistics
// are built only when RUN_CTRL_STATS_EN is defined.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | after rst; all domains in reset, waiting for start
// S_HOLD    | all domains held in reset for HOLD_CYCLES
// S_RELEASE | domains released one by one, WB first, STAGGER apart
// S_RUN     | core running; counting, waiting for halt_req or watchdog
// S_DRAIN   | pipeline draining for DRAIN_CYCLES after halt_req
// S_DONE    | run finished (done or timeout); core frozen, counts held
module core_run_ctrl
  import rv32i_sim_pkg::*;
#(
  parameter int NUM_CH       = 5,
  parameter int HOLD_CYCLES  = 3,
  parameter int STAGGER      = 1,
  parameter int DRAIN_CYCLES = 4,
  parameter int TIMEOUT      = 4096,
  parameter int CNT_W        = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              halt_req,
  input  logic              retire,
  output logic [NUM_CH-1:0] ch_rst_n,
  output logic              running,
  output logic              done,
  output logic              timeout,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  retired_count
);

  localparam int TMR_MAX = max_i(max_i(HOLD_CYCLES - 1, STAGGER - 1),
                                 max_i(DRAIN_CYCLES - 1, 1));
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [TMR_W-1:0] HOLD_LD  = TMR_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
  localparam logic [TMR_W-1:0] STAG_LD  = TMR_W'((STAGGER > 0) ? STAGGER - 1 : 0);
  localparam logic [TMR_W-1:0] DRAIN_LD = TMR_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

  localparam logic [NUM_CH-1:0] CH_MSB = NUM_CH'(1) << (NUM_CH - 1);
  localparam logic [NUM_CH-1:0] CH_ALL = '1;

  localparam int              WD_LIM_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CNT_W:0]  WD_LIM   = (CNT_W + 1)'(WD_LIM_I);

  run_state_e        state_q, state_d;
  logic [NUM_CH-1:0] ch_q, ch_d;
  logic              done_q, done_d;
  logic              to_q, to_d;
  logic              running_q;
  logic [CNT_W-1:0]  cycle_q;
  logic              tmr_load, tmr_en, tmr_zero;
  logic [TMR_W-1:0]  tmr_val;
  logic              clr_cnt, cnt_en;
  logic              wd_hit;

  run_ctrl_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .zero     (tmr_zero)
  );

  // Watchdog fires on the cycle whose increment makes cycle_count reach TIMEOUT.
  assign wd_hit = (TIMEOUT != 0) && ({1'b0, cycle_q} >= WD_LIM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ch_q      <= '0;
      done_q    <= 1'b0;
      to_q      <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      done_q    <= done_d;
      to_q      <= to_d;
      running_q <= (state_d == S_RUN) || (state_d == S_DRAIN);
    end
  end

  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    done_d   = done_q;
    to_d     = to_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    tmr_en   = 1'b0;
    clr_cnt  = 1'b0;
    cnt_en   = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        ch_d = '0;
        if (start) begin
          state_d  = S_HOLD;
          tmr_load = 1'b1;
          tmr_val  = HOLD_LD;
          clr_cnt  = 1'b1;
          done_d   = 1'b0;
          to_d     = 1'b0;
        end
      end

      S_HOLD: begin
        ch_d = '0;
        if (tmr_zero) begin
          state_d  = S_RELEASE;
          ch_d     = (STAGGER == 0) ? CH_ALL : CH_MSB;
          tmr_load = 1'b1;
          tmr_val  = STAG_LD;
        end else begin
          tmr_en = 1'b1;
        end
      end

      // Released bits fill in from the MSB, so shifting right walks WB -> IF.
      S_RELEASE: begin
        if (&ch_q) begin
          state_d = S_RUN;
        end else if (tmr_zero) begin
          ch_d     = (ch_q >> 1) | CH_MSB;
          tmr_load = 1'b1;
          tmr_val  = STAG_LD;
        end else begin
          tmr_en = 1'b1;
        end
      end

      S_RUN: begin
        cnt_en = 1'b1;
        if (wd_hit) begin
          state_d = S_DONE;
          to_d    = 1'b1;
          ch_d    = '0;
        end else if (halt_req) begin
          if (DRAIN_CYCLES == 0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            ch_d    = '0;
          end else begin
            state_d  = S_DRAIN;
            tmr_load = 1'b1;
            tmr_val  = DRAIN_LD;
          end
        end
      end

      S_DRAIN: begin
        cnt_en = 1'b1;
        if (wd_hit) begin
          state_d = S_DONE;
          to_d    = 1'b1;
          ch_d    = '0;
        end else if (tmr_zero) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          ch_d    = '0;
        end else begin
          tmr_en = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        ch_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_q <= '0;
    end else if (clr_cnt) begin
      cycle_q <= '0;
    end else if (cnt_en && (cycle_q != '1)) begin
      cycle_q <= cycle_q + 1'b1;
    end
  end

`ifdef RUN_CTRL_STATS_EN
  logic [CNT_W-1:0] retired_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_q <= '0;
    end else if (clr_cnt) begin
      retired_q <= '0;
    end else if (cnt_en && retire && (retired_q != '1)) begin
      retired_q <= retired_q + 1'b1;
    end
  end

  assign retired_count = retired_q;
`else
  logic unused_retire;
  assign unused_retire = retire;
  assign retired_count = '0;
`endif

  assign ch_rst_n    = ch_q;
  assign running     = running_q;
  assign done        = done_q;
  assign timeout     = to_q;
  assign cycle_count = cycle_q;

endmodule

// File: tb/tb_core_run_ctrl.sv
// Directed bench for core_run_ctrl: four parameterisations exercised one after
// another with hand-computed expectations at each step.
module tb_core_run_ctrl;

`ifdef RUN_CTRL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] start = '0;
  logic [3:0] halt = '0;
  logic       retire = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  logic [4:0]  ch0, ch1, ch3;
  logic [0:0]  ch2;
  logic        run0, run1, run2, run3;
  logic        done0, done1, done2, done3;
  logic        to0, to1, to2, to3;
  logic [31:0] cc0, cc1, cc2, rc0, rc1, rc2;
  logic [3:0]  cc3, rc3;

  core_run_ctrl u0 (
    .clk(clk), .rst(rst), .start(start[0]), .halt_req(halt[0]), .retire(retire),
    .ch_rst_n(ch0), .running(run0), .done(done0), .timeout(to0),
    .cycle_count(cc0), .retired_count(rc0)
  );

  core_run_ctrl #(.TIMEOUT(16)) u1 (
    .clk(clk), .rst(rst), .start(start[1]), .halt_req(halt[1]), .retire(retire),
    .ch_rst_n(ch1), .running(run1), .done(done1), .timeout(to1),
    .cycle_count(cc1), .retired_count(rc1)
  );

  core_run_ctrl #(.NUM_CH(1), .STAGGER(0)) u2 (
    .clk(clk), .rst(rst), .start(start[2]), .halt_req(halt[2]), .retire(retire),
    .ch_rst_n(ch2), .running(run2), .done(done2), .timeout(to2),
    .cycle_count(cc2), .retired_count(rc2)
  );

  core_run_ctrl #(.CNT_W(4), .TIMEOUT(0)) u3 (
    .clk(clk), .rst(rst), .start(start[3]), .halt_req(halt[3]), .retire(retire),
    .ch_rst_n(ch3), .running(run3), .done(done3), .timeout(to3),
    .cycle_count(cc3), .retired_count(rc3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  logic [4:0] ch_tab  [9] = '{5'b00000, 5'b00000, 5'b00000, 5'b10000, 5'b11000,
                              5'b11100, 5'b11110, 5'b11111, 5'b11111};
  logic       run_tab [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    // reset state
    tick();
    tick();
    chk("rst_ch", 64'(ch0), 64'h0);
    chk("rst_running", 64'(run0), 64'h0);
    chk("rst_done", 64'(done0), 64'h0);
    chk("rst_timeout", 64'(to0), 64'h0);
    chk("rst_cycles", 64'(cc0), 64'h0);
    chk("rst_retired", 64'(rc0), 64'h0);

    // staggered release, WB first
    rst = 1'b0;
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    for (int k = 0; k < 9; k++) begin
      if (k > 0) tick();
      chk("seq_ch", 64'(ch0), 64'(ch_tab[k]));
      chk("seq_running", 64'(run0), 64'(run_tab[k]));
    end
    chk("run_start_cycles", 64'(cc0), 64'h0);

    // retire pulses, halt at cycle_count=10, drain 4
    retire = 1'b1;
    repeat (7) tick();
    retire = 1'b0;
    chk("run_cycles7", 64'(cc0), 64'd7);
    chk("retired7", 64'(rc0), STATS ? 64'd7 : 64'd0);
    repeat (3) tick();
    chk("run_cycles10", 64'(cc0), 64'd10);
    halt[0] = 1'b1;
    tick();
    halt[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) tick();
      chk("drain_running", 64'(run0), 64'h1);
      chk("drain_done", 64'(done0), 64'h0);
    end
    tick();
    chk("end_done", 64'(done0), 64'h1);
    chk("end_timeout", 64'(to0), 64'h0);
    chk("end_cycles", 64'(cc0), 64'd15);
    chk("end_ch", 64'(ch0), 64'h0);
    chk("end_running", 64'(run0), 64'h0);
    chk("end_retired", 64'(rc0), STATS ? 64'd7 : 64'd0);

    // watchdog at TIMEOUT=16
    start[1] = 1'b1;
    tick();
    start[1] = 1'b0;
    repeat (8) tick();
    chk("wd_running", 64'(run1), 64'h1);
    chk("wd_cycles0", 64'(cc1), 64'h0);
    repeat (15) tick();
    chk("wd_cycles15", 64'(cc1), 64'd15);
    chk("wd_not_yet", 64'(to1), 64'h0);
    tick();
    chk("wd_timeout", 64'(to1), 64'h1);
    chk("wd_done", 64'(done1), 64'h0);
    chk("wd_cycles16", 64'(cc1), 64'd16);
    chk("wd_ch", 64'(ch1), 64'h0);
    chk("wd_stopped", 64'(run1), 64'h0);

    // restart from DONE, halt on the final RUN cycle: timeout still wins
    start[1] = 1'b1;
    tick();
    start[1] = 1'b0;
    chk("wd2_clr_timeout", 64'(to1), 64'h0);
    chk("wd2_clr_cycles", 64'(cc1), 64'h0);
    repeat (8) tick();
    chk("wd2_running", 64'(run1), 64'h1);
    repeat (15) tick();
    halt[1] = 1'b1;
    tick();
    halt[1] = 1'b0;
    chk("wd2_timeout", 64'(to1), 64'h1);
    chk("wd2_done", 64'(done1), 64'h0);
    chk("wd2_cycles", 64'(cc1), 64'd16);
    chk("wd2_retired", 64'(rc1), 64'h0);

    // single domain, no stagger
    start[2] = 1'b1;
    tick();
    start[2] = 1'b0;
    chk("one_hold1", 64'(ch2), 64'h0);
    tick();
    tick();
    chk("one_hold3", 64'(ch2), 64'h0);
    tick();
    chk("one_release", 64'(ch2), 64'h1);
    chk("one_rel_running", 64'(run2), 64'h0);
    tick();
    chk("one_running", 64'(run2), 64'h1);
    chk("one_cycles0", 64'(cc2), 64'h0);
    repeat (3) tick();
    halt[2] = 1'b1;
    tick();
    halt[2] = 1'b0;
    chk("one_drain_cycles", 64'(cc2), 64'd4);
    repeat (4) tick();
    chk("one_done", 64'(done2), 64'h1);
    chk("one_timeout", 64'(to2), 64'h0);
    chk("one_cycles", 64'(cc2), 64'd8);
    chk("one_retired", 64'(rc2), 64'h0);
    start[2] = 1'b1;
    tick();
    start[2] = 1'b0;
    chk("one_restart_cycles", 64'(cc2), 64'h0);
    chk("one_restart_done", 64'(done2), 64'h0);

    // 4-bit counters saturate, no watchdog
    start[3] = 1'b1;
    tick();
    start[3] = 1'b0;
    repeat (8) tick();
    chk("sat_running", 64'(run3), 64'h1);
    chk("sat_cycles0", 64'(cc3), 64'h0);
    retire = 1'b1;
    repeat (20) tick();
    retire = 1'b0;
    chk("sat_cycles", 64'(cc3), 64'd15);
    chk("sat_retired", 64'(rc3), STATS ? 64'd15 : 64'd0);
    halt[3] = 1'b1;
    tick();
    halt[3] = 1'b0;
    repeat (4) tick();
    chk("sat_done", 64'(done3), 64'h1);
    chk("sat_timeout", 64'(to3), 64'h0);
    chk("sat_end_cycles", 64'(cc3), 64'd15);
    chk("sat_ch", 64'(ch3), 64'h0);

    // async reset during DRAIN
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    chk("rs_clr_done", 64'(done0), 64'h0);
    chk("rs_clr_cycles", 64'(cc0), 64'h0);
    repeat (8) tick();
    chk("rs_running", 64'(run0), 64'h1);
    chk("rs_ch_all", 64'(ch0), 64'h1f);
    repeat (2) tick();
    halt[0] = 1'b1;
    tick();
    halt[0] = 1'b0;
    chk("rs_in_drain", 64'(run0), 64'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("rs_async_ch", 64'(ch0), 64'h0);
    chk("rs_async_running", 64'(run0), 64'h0);
    chk("rs_async_done", 64'(done0), 64'h0);
    chk("rs_async_cycles", 64'(cc0), 64'h0);
    tick();
    rst = 1'b0;
    tick();
    chk("rs_idle_ch", 64'(ch0), 64'h0);
    chk("rs_idle_running", 64'(run0), 64'h0);
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    repeat (3) tick();
    chk("rs_restart_release", 64'(ch0), 64'h10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
